// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes and multiplier sequencer state type.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier that borrows the shared ALU via req/gnt.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPS_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic [OPS_W-1:0] out_ops,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);
  mul_state_t state, state_nx;
  logic [WIDTH-1:0] p, m, q;
  logic [OPS_W-1:0] ops;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (in_b == '0) ? DONE : (in_b[0] ? ADD : SHIFT);
      ADD:     if (alu_gnt) state_nx = (q[WIDTH-1:1] == '0) ? DONE : SHIFT;
      SHIFT:   if (alu_gnt) state_nx = q[1] ? ADD : SHIFT;
      default: if (out_ready) state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    alu_req   = state == ADD || state == SHIFT;
    alu_ctl   = state == SHIFT ? ALU_SLL : ALU_ADD;
    alu_a     = state == ADD ? p : (state == SHIFT ? m : '0);
    alu_b     = state == ADD ? m : (state == SHIFT ? WIDTH'(1) : '0);
  end
  // Grant only moves the datapath while a request is up, so stray grants are harmless.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p   <= '0;
      m   <= '0;
      q   <= '0;
      ops <= '0;
    end else if (state == IDLE && in_valid) begin
      p   <= '0;
      m   <= in_a;
      q   <= in_b;
      ops <= '0;
    end else if (alu_req && alu_gnt) begin
      ops <= ops + OPS_W'(1);
      if (state == ADD) p <= alu_out;
      else begin
        m <= alu_out;
        q <= q >> 1;
      end
    end
  assign out_prod = p;
  assign out_ops  = ops;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: table, corner-case and random checks against an arithmetic model.
module tb_alu_mul_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, alu_gnt = 0;
  logic [31:0] in_a = 0, in_b = 0, alu_out, alu_a, alu_b, out_prod;
  logic in_ready, out_valid, alu_req;
  logic [3:0] alu_ctl;
  logic [5:0] out_ops;
  int total = 0, bad = 0, mode = 0, alu_cyc = 0;
  logic phase = 0, prev_req = 0, prev_gnt = 0;
  logic [3:0] prev_ctl = 0;
  logic [31:0] prev_a = 0, prev_b = 0;
  logic [3:0] ctl_log[$];
  logic [31:0] a_log[$];

  alu_mul_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_ops(out_ops), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out));

  always #5 clk = ~clk;
  assign alu_out = alu_ctl == 4'd2 ? alu_a + alu_b : (alu_ctl == 4'd3 ? alu_a << alu_b[4:0] : 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_ops(input logic [31:0] b);
    int n = 0, msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) begin n++; msb = i; end
    return b == 0 ? 0 : n + msb;
  endfunction

  // Grant pattern: 0 = always granted (even without request), 1 = alternate from 0, 2 = random.
  always @(negedge clk) begin
    if (alu_req) begin
      alu_gnt = mode == 0 ? 1'b1 : (mode == 1 ? phase : 1'($urandom));
      phase = ~phase;
    end else begin
      alu_gnt = mode == 0;
      phase = 0;
    end
  end

  always @(posedge clk) begin
    if (alu_req) begin
      alu_cyc++;
      if (prev_req && !prev_gnt) begin
        chk("hold_ctl", {28'd0, alu_ctl}, {28'd0, prev_ctl});
        chk("hold_a", alu_a, prev_a);
        chk("hold_b", alu_b, prev_b);
      end
      if (alu_gnt) begin
        ctl_log.push_back(alu_ctl);
        a_log.push_back(alu_a);
      end
    end else if (alu_ctl != 4'd2 || alu_a != 0 || alu_b != 0) begin
      chk("idle_alu_bus", {alu_ctl, alu_a[27:0]}, 32'h2000_0000);
    end
    prev_req = alu_req;
    prev_gnt = alu_gnt;
    prev_ctl = alu_ctl;
    prev_a = alu_a;
    prev_b = alu_b;
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic take_result();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_after_take", {31'd0, in_ready}, 1);
    chk("valid_drop", {31'd0, out_valid}, 0);
  endtask

  typedef struct { logic [31:0] a, b, prod; int ops, lat; } vec_t;
  vec_t v[9];

  initial begin
    int lat, base, c0;
    logic [31:0] a, b;
    v[0] = '{32'd7, 32'd5, 32'd35, 4, 5};
    v[1] = '{32'd123, 32'd0, 32'd0, 0, 1};
    v[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 63, 64};
    v[3] = '{32'd1, 32'd1, 32'd1, 1, 2};
    v[4] = '{32'h8000_0000, 32'd2, 32'd0, 2, 3};
    v[5] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32, 33};
    v[6] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2, 3};
    v[7] = '{32'h1_0000, 32'h100, 32'h100_0000, 9, 10};
    v[8] = '{32'd6, 32'd7, 32'd42, 5, 6};
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_alu_req", {31'd0, alu_req}, 0);
    chk("rst_alu_ctl", {28'd0, alu_ctl}, 2);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_prod", out_prod, 0);
    chk("rst_ops", {26'd0, out_ops}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      base = ctl_log.size();
      c0 = alu_cyc;
      start_op(v[i].a, v[i].b);
      wait_done(lat);
      chk($sformatf("vec%0d_prod", i), out_prod, v[i].prod);
      chk($sformatf("vec%0d_ops", i), {26'd0, out_ops}, 32'(v[i].ops));
      chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
      if (i == 0 && ctl_log.size() == base + 4) begin
        chk("seq_ctl", {ctl_log[base], ctl_log[base+1], ctl_log[base+2], ctl_log[base+3], 16'd0}, 32'h2332_0000);
        chk("seq_a0", a_log[base], 0);
        chk("seq_a1", a_log[base+1], 7);
        chk("seq_a2", a_log[base+2], 14);
        chk("seq_a3", a_log[base+3], 7);
      end else if (i == 0) chk("seq_len", ctl_log.size() - base, 4);
      if (i == 1) chk("b0_no_req", alu_cyc - c0, 0);
      take_result();
    end
    mode = 1;
    c0 = alu_cyc;
    start_op(32'd3, 32'd3);
    wait_done(lat);
    chk("alt_prod", out_prod, 9);
    chk("alt_ops", {26'd0, out_ops}, 3);
    chk("alt_alu_cycles", alu_cyc - c0, 6);
    chk("alt_lat", lat, 7);
    take_result();
    mode = 0;
    start_op(32'd9, 32'd3);
    wait_done(lat);
    in_valid = 1; in_a = 55; in_b = 66;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_prod", out_prod, 27);
      chk("stall_ready", {31'd0, in_ready}, 0);
    end
    in_valid = 0;
    take_result();
    chk("no_capture", out_prod, 27);
    start_op(32'h1_0000, 32'h100);
    @(posedge clk); #1;
    chk("mid_shift_ctl", {27'd0, alu_req, alu_ctl}, 32'h13);
    rst_n = 0;
    #1;
    chk("abort_req", {31'd0, alu_req}, 0);
    chk("abort_valid", {31'd0, out_valid}, 0);
    chk("abort_ready", {31'd0, in_ready}, 1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    start_op(32'd6, 32'd7);
    wait_done(lat);
    chk("post_rst_prod", out_prod, 42);
    chk("post_rst_ops", {26'd0, out_ops}, 5);
    take_result();
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      start_op(a, b);
      wait_done(lat);
      chk("rnd_prod", out_prod, a * b);
      chk("rnd_ops", {26'd0, out_ops}, 32'(model_ops(b)));
      if (lat < 1 + model_ops(b)) chk("rnd_lat_min", lat, 1 + model_ops(b));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold", out_prod, a * b);
      end
      take_result();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
